// File: rtl/bcd_serial_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_serial_addsub
// Purpose  : Digit-serial packed-BCD adder/subtractor, LSD first, one digit
//            per clock, start/busy/done handshake, invalid-digit detection.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_sub,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_sum,
    output logic                  o_cout,
    output logic                  o_invalid
);

    localparam int              c_W    = 4 * DIGITS;
    localparam int              c_CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_W-1:0]    r_a;
    logic [c_W-1:0]    r_b;
    logic [c_W-1:0]    r_res;
    logic              r_sub;
    logic              r_carry;
    logic [c_CW-1:0]   r_cnt;

    logic [DIGITS-1:0] w_bad;
    logic [3:0]        w_bd_eff;
    logic [4:0]        w_t;
    logic              w_gt9;
    logic [3:0]        w_t_adj;
    logic [3:0]        w_digit;
    logic [c_W-1:0]    w_res_next;

    // Flag any operand digit in 10..15 directly on the inputs, so the check
    // is ready at the edge that accepts start.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign w_bad[gi] = (i_a[4*gi +: 4] > 4'd9) | (i_b[4*gi +: 4] > 4'd9);
        end
    endgenerate

    // One decimal digit step: nine's complement of B for subtract, binary sum
    // with carry, then +6 correction when the sum leaves the decimal range.
    // The +6 is only needed mod 16, so a 4-bit add suffices.
    assign w_bd_eff   = r_sub ? (4'd9 - r_b[3:0]) : r_b[3:0];
    assign w_t        = {1'b0, r_a[3:0]} + {1'b0, w_bd_eff} + {4'd0, r_carry};
    assign w_gt9      = (w_t > 5'd9);
    assign w_t_adj    = w_t[3:0] + 4'd6;
    assign w_digit    = w_gt9 ? w_t_adj : w_t[3:0];
    // New digit enters at the top; after DIGITS steps digit 0 sits at [3:0].
    assign w_res_next = (r_res >> 4) | (c_W'(w_digit) << (c_W - 4));

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_sum     <= '0;
            o_cout    <= 1'b0;
            o_invalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_sub   <= i_sub;
                        r_cnt   <= '0;
                        r_carry <= i_sub;  // ten's complement = nine's + 1
                        r_res   <= '0;
                        o_sum   <= '0;
                        o_cout  <= 1'b0;
                        o_busy  <= 1'b1;
                        if (|w_bad) begin
                            // Bad operand: report straight away, skip RUN.
                            o_invalid <= 1'b1;
                            o_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            o_invalid <= 1'b0;
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_gt9;
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + c_CW'(1);
                    if (r_cnt == c_LAST) begin
                        o_sum   <= w_res_next;
                        // For subtract a final carry means no borrow.
                        o_cout  <= r_sub ? ~w_gt9 : w_gt9;
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bcd_serial_addsub
// Purpose  : Directed self-checking bench for bcd_serial_addsub (DIGITS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_addsub;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sub = 1'b0;
    logic [4*D-1:0] a = '0;
    logic [4*D-1:0] b = '0;
    logic          busy;
    logic          done;
    logic [4*D-1:0] sum;
    logic          cout;
    logic          invalid;

    int errors = 0;
    int checks = 0;

    bcd_serial_addsub #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (start),
        .i_sub     (sub),
        .i_a       (a),
        .i_b       (b),
        .o_busy    (busy),
        .o_done    (done),
        .o_sum     (sum),
        .o_cout    (cout),
        .o_invalid (invalid)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE; returns the results seen while done is
    // high and the start-to-done latency in cycles. Leaves the DUT in IDLE.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic ts, output logic [15:0] s,
                          output logic c, output logic inv, output int lat);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        s = sum; c = cout; inv = invalid;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        checks++; if (cout !== 1'b0 || invalid !== 1'b0) begin errors++; $display("FAIL reset_flags: got cout=%b inv=%b expected 0 0", cout, invalid); end
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_add();
        logic [15:0] va [3] = '{16'h0025, 16'h9999, 16'h0099};
        logic [15:0] vb [3] = '{16'h0052, 16'h0001, 16'h0088};
        logic [15:0] vs [3] = '{16'h0077, 16'h0000, 16'h0187};
        logic        vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] s;
        logic        c, inv;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, s, c, inv, lat);
            checks++; if (s !== vs[i]) begin errors++; $display("FAIL add_sum[%0d]: got %h expected %h", i, s, vs[i]); end
            checks++; if (c !== vc[i]) begin errors++; $display("FAIL add_cout[%0d]: got %b expected %b", i, c, vc[i]); end
            checks++; if (inv !== 1'b0) begin errors++; $display("FAIL add_invalid[%0d]: got %b expected 0", i, inv); end
            checks++; if (lat != 5) begin errors++; $display("FAIL add_latency[%0d]: got %0d expected 5", i, lat); end
        end
    endtask

    task automatic test_sub();
        logic [15:0] va [3] = '{16'h0093, 16'h0012, 16'h5000};
        logic [15:0] vb [3] = '{16'h0012, 16'h0093, 16'h5000};
        logic [15:0] vs [3] = '{16'h0081, 16'h9919, 16'h0000};
        logic        vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] s;
        logic        c, inv;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b1, s, c, inv, lat);
            checks++; if (s !== vs[i]) begin errors++; $display("FAIL sub_sum[%0d]: got %h expected %h", i, s, vs[i]); end
            checks++; if (c !== vc[i]) begin errors++; $display("FAIL sub_borrow[%0d]: got %b expected %b", i, c, vc[i]); end
            checks++; if (lat != 5) begin errors++; $display("FAIL sub_latency[%0d]: got %0d expected 5", i, lat); end
        end
    endtask

    task automatic test_invalid();
        logic [15:0] s;
        logic        c, inv;
        int          lat;
        run_op(16'h00A5, 16'h0001, 1'b0, s, c, inv, lat);
        checks++; if (inv !== 1'b1) begin errors++; $display("FAIL inv_a_flag: got %b expected 1", inv); end
        checks++; if (s !== 16'h0000 || c !== 1'b0) begin errors++; $display("FAIL inv_a_result: got sum=%h cout=%b expected 0000 0", s, c); end
        checks++; if (lat != 1) begin errors++; $display("FAIL inv_a_latency: got %0d expected 1", lat); end
        run_op(16'h0012, 16'hF000, 1'b1, s, c, inv, lat);
        checks++; if (inv !== 1'b1 || s !== 16'h0000 || c !== 1'b0) begin errors++; $display("FAIL inv_b: got inv=%b sum=%h cout=%b expected 1 0000 0", inv, s, c); end
        checks++; if (lat != 1) begin errors++; $display("FAIL inv_b_latency: got %0d expected 1", lat); end
        run_op(16'h0001, 16'h0002, 1'b0, s, c, inv, lat);
        checks++; if (inv !== 1'b0 || s !== 16'h0003) begin errors++; $display("FAIL inv_clear: got inv=%b sum=%h expected 0 0003", inv, s); end
    endtask

    task automatic test_ignore_start();
        a = 16'h0025; b = 16'h0052; sub = 1'b0; start = 1'b1;
        tick();                                   // edge 0 accepts
        a = 16'h1111; b = 16'h2222; sub = 1'b1;   // start stays high in RUN/DONE
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy_rise: got %b expected 1", busy); end
        for (int k = 1; k <= 4; k++) tick();
        checks++; if (done !== 1'b1 || sum !== 16'h0077 || cout !== 1'b0) begin errors++; $display("FAIL ign_result: got done=%b sum=%h cout=%b expected 1 0077 0", done, sum, cout); end
        tick();                                   // edge 5: DONE -> IDLE
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ign_done_start: got busy=%b done=%b expected 0 0", busy, done); end
        tick();
        checks++; if (busy !== 1'b0 || sum !== 16'h0077) begin errors++; $display("FAIL ign_hold: got busy=%b sum=%h expected 0 0077", busy, sum); end
    endtask

    task automatic test_back_to_back();
        a = 16'h0025; b = 16'h0052; sub = 1'b0; start = 1'b1;
        tick();                                   // edge 0
        a = 16'h0100; b = 16'h0200;
        for (int k = 1; k <= 4; k++) tick();
        checks++; if (done !== 1'b1 || sum !== 16'h0077) begin errors++; $display("FAIL b2b_first: got done=%b sum=%h expected 1 0077", done, sum); end
        tick();                                   // edge 5
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got busy=%b expected 0", busy); end
        tick();                                   // edge 6 accepts second
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
        start = 1'b0;
        for (int k = 7; k <= 9; k++) tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_early_done: got %b expected 0", done); end
        tick();                                   // edge 10
        checks++; if (done !== 1'b1 || sum !== 16'h0300 || cout !== 1'b0) begin errors++; $display("FAIL b2b_second: got done=%b sum=%h cout=%b expected 1 0300 0", done, sum, cout); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [15:0] s;
        logic        c, inv;
        int          lat;
        int          seen;
        a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();                           // digits 0 and 1 processed
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_running: got busy=%b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || invalid !== 1'b0) begin
            errors++; $display("FAIL rmid_async: got busy=%b done=%b sum=%h cout=%b inv=%b expected all 0", busy, done, sum, cout, invalid);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_done: got %0d done pulses expected 0", seen); end
        run_op(16'h0001, 16'h0001, 1'b0, s, c, inv, lat);
        checks++; if (s !== 16'h0002 || c !== 1'b0 || lat != 5) begin errors++; $display("FAIL rmid_recover: got sum=%h cout=%b lat=%0d expected 0002 0 5", s, c, lat); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_invalid();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
